mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder
//   CPU-facing memory and IO responder. Serves a byte-wide RAM, a UART
//   receive buffer, a snapshot-able free-running cycle counter and a TX FIFO
//   toward the UART. Every CPU cycle is an access: mem_wr=1 writes,
//   mem_wr=0 reads. Read data appears one cycle after the address.
//
//   IO map (mem_a[17:16] == 2'b11, offset = mem_a[15:0]):
//     0x0000  W: push byte to TX FIFO (0x00 ignored)  R: rx buffer, clears rx_has
//     0x0004  W: set program_done, push 0x00           R: snapshot counter, byte 0
//     0x0005..0x0007  R: snapshot bytes 1..3
//
// Ports
//   clk_in          system clock, rising edge
//   rst_in          asynchronous active-low reset
//   mem_a           CPU address (bits 17:0 decoded)
//   mem_dout        CPU write data
//   mem_wr          1 = write, 0 = read
//   mem_din         read data to the CPU (0x00 after a write)
//   io_buffer_full  registered TX FIFO near-full (count >= TX_DEPTH-2)
//   tx_data         UART transmit byte (FIFO head, 0 when empty)
//   tx_valid        TX FIFO not empty
//   tx_ready        UART takes the head byte this cycle
//   rx_data         UART received byte
//   rx_valid        rx_data valid this cycle
//   program_done    sticky program-stop flag
//   tx_overflow     sticky flag: a push was dropped because the FIFO was full
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_done,
    output logic        tx_overflow
);

    localparam int PTR_W    = $clog2(TX_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int RAM_SIZE = 1 << RAM_ADDR_W;

    // Address decode
    logic                  w_is_io;
    logic [15:0]           w_io_off;
    logic [RAM_ADDR_W-1:0] w_ram_idx;
    logic                  w_rd_rx;
    logic                  w_rd_cnt0;
    logic                  w_wr_tx;
    logic                  w_wr_done;
    logic                  w_unused_addr;

    assign w_is_io       = (mem_a[17:16] == 2'b11);
    assign w_io_off      = mem_a[15:0];
    assign w_ram_idx     = mem_a[RAM_ADDR_W-1:0];
    assign w_rd_rx       = !mem_wr && w_is_io && (w_io_off == 16'h0000);
    assign w_rd_cnt0     = !mem_wr && w_is_io && (w_io_off == 16'h0004);
    assign w_wr_tx       = mem_wr && w_is_io && (w_io_off == 16'h0000);
    assign w_wr_done     = mem_wr && w_is_io && (w_io_off == 16'h0004);
    assign w_unused_addr = ^mem_a[31:18];

    // RAM: kept out of the reset domain so contents survive reset and the
    // array can map onto block memory with a registered read port.
    logic [7:0] r_ram [RAM_SIZE];
    logic [7:0] r_ram_q;

    always_ff @(posedge clk_in) begin
        if (mem_wr && !w_is_io) begin
            r_ram[w_ram_idx] <= mem_dout;
        end
        r_ram_q <= r_ram[w_ram_idx];
    end

    // Registered state in the reset domain
    logic [31:0]      r_cycle;
    logic [31:0]      r_snap;
    logic [7:0]       r_rx_buf;
    logic             r_rx_has;
    logic             r_src_ram;
    logic [7:0]       r_io_q;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_buf_full;
    logic             r_done;
    logic             r_ovf;
    logic [7:0]       r_fifo [TX_DEPTH];

    // IO read data for this cycle's address; 0 on writes and unmapped offsets
    logic [7:0] w_io_rd_data;

    always_comb begin
        w_io_rd_data = 8'h00;
        if (!mem_wr && w_is_io) begin
            case (w_io_off)
                16'h0000: w_io_rd_data = r_rx_has ? r_rx_buf : 8'h00;
                16'h0004: w_io_rd_data = r_cycle[7:0];
                16'h0005: w_io_rd_data = r_snap[15:8];
                16'h0006: w_io_rd_data = r_snap[23:16];
                16'h0007: w_io_rd_data = r_snap[31:24];
                default:  w_io_rd_data = 8'h00;
            endcase
        end
    end

    // TX FIFO control
    logic             w_push;
    logic [7:0]       w_push_data;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_push_ok;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_push      = (w_wr_tx && (mem_dout != 8'h00)) || w_wr_done;
    assign w_push_data = w_wr_done ? 8'h00 : mem_dout;
    assign w_pop       = (r_count != '0) && tx_ready;
    assign w_fifo_full = (r_count == CNT_W'(TX_DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign w_push_ok   = w_push && (!w_fifo_full || w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_fifo[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cycle    <= '0;
            r_snap     <= '0;
            r_rx_buf   <= '0;
            r_rx_has   <= 1'b0;
            r_src_ram  <= 1'b0;
            r_io_q     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_buf_full <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_cycle   <= r_cycle + 32'd1;
            r_src_ram <= !mem_wr && !w_is_io;
            r_io_q    <= w_io_rd_data;

            if (w_rd_cnt0) begin
                r_snap <= r_cycle;
            end

            // A new byte wins over the read-clear in the same cycle; the read
            // itself already took the old buffer value above.
            if (rx_valid) begin
                r_rx_buf <= rx_data;
                r_rx_has <= 1'b1;
            end else if (w_rd_rx) begin
                r_rx_has <= 1'b0;
            end

            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_buf_full <= (w_count_nxt >= CNT_W'(TX_DEPTH - 2));

            if (w_wr_done) begin
                r_done <= 1'b1;
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // r_src_ram resets low, so mem_din reads the cleared IO register in reset
    assign mem_din        = r_src_ram ? r_ram_q : r_io_q;
    assign io_buffer_full = r_buf_full;
    assign tx_valid       = (r_count != '0);
    assign tx_data        = tx_valid ? r_fifo[r_rptr] : 8'h00;
    assign program_done   = r_done;
    assign tx_overflow    = r_ovf;

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    localparam int TX_DEPTH = 8;
    localparam logic [31:0] IDLE_A = 32'h0003_0010;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] mem_a = IDLE_A;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        program_done;
    logic        tx_overflow;

    int n_vec = 0;
    int n_err = 0;

    mem_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH(TX_DEPTH)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .mem_a(mem_a),
        .mem_dout(mem_dout),
        .mem_wr(mem_wr),
        .mem_din(mem_din),
        .io_buffer_full(io_buffer_full),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .program_done(program_done),
        .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [7:0]  ram_m [int];
    logic [7:0]  m_q [$];
    logic [7:0]  m_din = 8'h00;
    bit          m_din_known = 1'b1;
    bit          m_full = 1'b0;
    bit          m_done = 1'b0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_snap = 32'd0;
    logic [7:0]  m_rx_buf = 8'h00;
    bit          m_rx_has = 1'b0;

    always @(posedge clk_in or negedge rst_in) begin
        logic [17:0] off;
        bit          io;
        bit          push;
        logic [7:0]  pd;
        if (!rst_in) begin
            m_q.delete();
            m_din = 8'h00;
            m_din_known = 1'b1;
            m_full = 1'b0;
            m_done = 1'b0;
            m_ovf = 1'b0;
            m_cyc = 32'd0;
            m_snap = 32'd0;
            m_rx_has = 1'b0;
        end else begin
            off = mem_a[17:0];
            io = (off[17:16] == 2'b11);
            push = 1'b0;
            pd = 8'h00;
            m_din = 8'h00;
            m_din_known = 1'b1;
            if (!mem_wr) begin
                if (io) begin
                    case (off)
                        18'h30000: m_din = m_rx_has ? m_rx_buf : 8'h00;
                        18'h30004: begin m_din = m_cyc[7:0]; m_snap = m_cyc; end
                        18'h30005: m_din = 8'((m_snap >> 8) & 32'hFF);
                        18'h30006: m_din = 8'((m_snap >> 16) & 32'hFF);
                        18'h30007: m_din = 8'((m_snap >> 24) & 32'hFF);
                        default:   m_din = 8'h00;
                    endcase
                end else if (ram_m.exists(int'(off[16:0]))) begin
                    m_din = ram_m[int'(off[16:0])];
                end else begin
                    m_din_known = 1'b0;
                end
            end else begin
                if (!io) ram_m[int'(off[16:0])] = mem_dout;
                else if (off == 18'h30000 && mem_dout != 8'h00) begin push = 1'b1; pd = mem_dout; end
                else if (off == 18'h30004) begin push = 1'b1; pd = 8'h00; m_done = 1'b1; end
            end
            if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < TX_DEPTH) m_q.push_back(pd);
                else m_ovf = 1'b1;
            end
            if (!mem_wr && off == 18'h30000) m_rx_has = 1'b0;
            if (rx_valid) begin m_rx_buf = rx_data; m_rx_has = 1'b1; end
            m_full = (m_q.size() >= TX_DEPTH - 2);
            m_cyc = m_cyc + 32'd1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_in) begin
        if (m_din_known) chk("mem_din", 32'(mem_din), 32'(m_din));
        chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        chk("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("io_buffer_full", 32'(io_buffer_full), 32'(m_full));
        chk("program_done", 32'(program_done), 32'(m_done));
        chk("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    end

    // One access: apply, take the edge, return 1 time unit after it.
    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a = a;
        mem_wr = wr;
        mem_dout = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        cyc(IDLE_A, 1'b0, 8'h00);
    endtask

    initial begin
        logic [31:0] snap;
        logic [17:0] off;
        logic [1:0]  bank;

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst mem_din", 32'(mem_din), 32'h0);
        chk("rst tx_valid", 32'(tx_valid), 32'h0);
        chk("rst io_buffer_full", 32'(io_buffer_full), 32'h0);
        rst_in = 1'b1;

        // Counter snapshot: read at cycle 100 assembles to 100
        repeat (100) idle();
        cyc(32'h0003_0004, 1'b0, 8'h00);
        snap[7:0] = mem_din;
        cyc(32'h0003_0005, 1'b0, 8'h00);
        snap[15:8] = mem_din;
        cyc(32'h0003_0006, 1'b0, 8'h00);
        snap[23:16] = mem_din;
        cyc(32'h0003_0007, 1'b0, 8'h00);
        snap[31:24] = mem_din;
        chk("snapshot value", snap, 32'd100);

        // RAM write then read
        cyc(32'h0000_0010, 1'b1, 8'hA5);
        chk("mem_din after write", 32'(mem_din), 32'h0);
        cyc(32'h0000_0010, 1'b0, 8'h00);
        chk("ram readback", 32'(mem_din), 32'hA5);

        // TX FIFO fill, near-full, overflow, drain
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cyc(32'h0003_0000, 1'b1, 8'h41);
            if (i == 5) chk("full after 5", 32'(io_buffer_full), 32'h0);
            if (i == 6) chk("full after 6", 32'(io_buffer_full), 32'h1);
            if (i == 8) chk("no ovf at 8", 32'(tx_overflow), 32'h0);
            if (i == 9) chk("ovf at 9", 32'(tx_overflow), 32'h1);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain valid", 32'(tx_valid), 32'h1);
            chk("drain data", 32'(tx_data), 32'h41);
            idle();
        end
        chk("drained", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Zero byte ignored; 0x30004 write flags done and pushes 0x00
        cyc(32'h0003_0000, 1'b1, 8'h00);
        chk("zero push ignored", 32'(tx_valid), 32'h0);
        cyc(32'h0003_0004, 1'b1, 8'h5A);
        chk("program_done", 32'(program_done), 32'h1);
        chk("stop push valid", 32'(tx_valid), 32'h1);
        chk("stop push data", 32'(tx_data), 32'h00);
        tx_ready = 1'b1;
        idle();
        chk("stop byte popped", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // RX buffer
        rx_valid = 1'b1;
        rx_data = 8'h7E;
        idle();
        rx_valid = 1'b0;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        chk("rx first read", 32'(mem_din), 32'h7E);
        cyc(32'h0003_0000, 1'b0, 8'h00);
        chk("rx second read", 32'(mem_din), 32'h00);
        rx_valid = 1'b1;
        rx_data = 8'h11;
        idle();
        rx_data = 8'h22;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        chk("rx coincident old", 32'(mem_din), 32'h11);
        rx_valid = 1'b0;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        chk("rx coincident new", 32'(mem_din), 32'h22);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                bank = 2'($urandom_range(0, 2));
                off = {bank, 16'($urandom_range(0, 31))};
            end else if ($urandom_range(0, 9) == 0) begin
                off = 18'h30010;
            end else begin
                off = 18'h30000 + 18'($urandom_range(0, 8));
            end
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data = 8'($urandom);
            cyc({14'($urandom), off}, ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        end
        rx_valid = 1'b0;

        // Asynchronous reset mid-transfer
        tx_ready = 1'b0;
        cyc(32'h0000_0123, 1'b1, 8'h3C);
        cyc(32'h0003_0000, 1'b1, 8'h55);
        cyc(32'h0000_0123, 1'b0, 8'h00);
        chk("pre-reset readback", 32'(mem_din), 32'h3C);
        chk("pre-reset tx_valid", 32'(tx_valid), 32'h1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async mem_din", 32'(mem_din), 32'h0);
        chk("async io_buffer_full", 32'(io_buffer_full), 32'h0);
        chk("async tx_valid", 32'(tx_valid), 32'h0);
        chk("async tx_data", 32'(tx_data), 32'h0);
        chk("async program_done", 32'(program_done), 32'h0);
        chk("async tx_overflow", 32'(tx_overflow), 32'h0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        idle();
        chk("post-reset tx_valid", 32'(tx_valid), 32'h0);
        cyc(32'h0000_0123, 1'b0, 8'h00);
        chk("ram survives reset", 32'(mem_din), 32'h3C);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
